// File: rtl/tube_pkg.sv
// Shared Tube constants: register data width, empty-read value, default
// per-register FIFO depths and a constant-evaluable clog2 for port sizing.
package tube_pkg;

  localparam int unsigned TUBE_DATA_W       = 8;
  localparam logic [7:0]  TUBE_EMPTY_VAL    = 8'hAA;

  // R1 holds 24 bytes; storage depth is rounded up to the next power of two.
  localparam int unsigned TUBE_R1_DEPTH_RAW = 24;
  localparam int unsigned TUBE_R1_DEPTH     = 32;
  localparam int unsigned TUBE_R3_DEPTH_TWO = 2;
  localparam int unsigned TUBE_R3_DEPTH     = 16;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tube_fifo_ram.sv
// FIFO storage: WIDTH x DEPTH array, synchronous write, asynchronous read.
// Isolated so the distributed-RAM inference stays in one place.
module tube_fifo_ram
  import tube_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tube_fifo_sync.sv
// Single-clock Tube data-register FIFO with two-entry limit mode, flush and
// occupancy status. Sticky overflow/underflow flags built only with TUBE_FIFO_ERRFLAGS_EN.
module tube_fifo_sync
  import tube_pkg::*;
#(
  parameter int unsigned      WIDTH     = TUBE_DATA_W,
  parameter int unsigned      DEPTH     = TUBE_R3_DEPTH,
  parameter int unsigned      AF_LEVEL  = DEPTH - 2,
  parameter logic [WIDTH-1:0] EMPTY_VAL = WIDTH'(TUBE_EMPTY_VAL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   limit_two,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   data_available,
  output logic                   full,
  output logic                   almost_full,
  output logic [clog2(DEPTH):0]  count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cap;
  logic             rd_acc;
  logic             wr_acc;
  logic [WIDTH-1:0] head;

  always_comb begin
    cap    = limit_two ? CW'(2) : CW'(DEPTH);
    rd_acc = !flush && rd_en && (count != '0);
    // Read-through write only when exactly at capacity, so an over-limit
    // FIFO (limit_two raised with count > 2) keeps rejecting until it drains.
    wr_acc = !flush && wr_en && ((count < cap) || (rd_acc && (count == cap)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  tube_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_comb begin
    data_available = (count != '0);
    full           = (count >= cap);
    almost_full    = (count >= CW'(AF_LEVEL));
    rd_data        = data_available ? head : EMPTY_VAL;
  end

`ifdef TUBE_FIFO_ERRFLAGS_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (flush) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en && !wr_acc)       ovf_q <= 1'b1;
      if (rd_en && (count == '0)) unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: doc/tube_fifo_sync.md
Name: tube_fifo_sync

Overview:
- Parametrised single-clock FIFO for Tube inter-processor data registers, replacing the fixed 8-bit dual-clock vendor-core FIFO.
- Host and parasite accesses arrive as one-cycle enables already synchronised into the system clock domain.
- Adds configurable width/depth, a Tube "two-byte" depth-limit mode, flush, an almost-full threshold and an occupancy count.
- Keeps the 0xAA-on-empty read convention.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 16, storage entries; power of two, >=2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- EMPTY_VAL, 8'hAA (zero-extended to WIDTH), value driven on rd_data while empty.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous clear of contents (Tube soft reset).
- limit_two  in  1  when 1, effective capacity is 2 entries (Tube R3 V-flag mode).
- wr_en  in  1  parasite write strobe, one cycle per byte.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  host read strobe; pops the head entry.
- rd_data  out  WIDTH  head entry (show-ahead), EMPTY_VAL when empty.
- data_available  out  1  count != 0.
- full  out  1  count >= effective capacity.
- almost_full  out  1  count >= AF_LEVEL (ignores limit_two).
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: write dropped (see Optional Feature).
- underflow  out  1  sticky: read of empty FIFO (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): pointers=0, count=0, data_available=0, full=0, almost_full=0, overflow=0, underflow=0, rd_data=EMPTY_VAL. Storage contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is an explicit register: +1 on accepted write only, -1 on accepted read only, unchanged on both.
- Effective capacity = 2 if limit_two, else DEPTH.
- Read accepted iff rd_en and count != 0. Rejected read changes no state.
- Write accepted iff wr_en and (count < capacity, or a read is accepted the same cycle).
  - Full plus simultaneous read and write: both accepted, count unchanged.
  - Empty plus simultaneous read and write: read rejected, write accepted, count becomes 1.
  - New data never bypasses to rd_data in the write cycle.
- Latency:
  - Written entry is visible on rd_data and data_available the cycle after the accepting edge.
  - Pop advances rd_data the cycle after the accepting edge.
  - rd_data is a combinational read of the storage head, muxed to EMPTY_VAL when count==0.
- Status outputs are combinational decodes of registered count/limit_two, with no extra latency.
- limit_two changes take effect immediately for accept decisions. If set while count > 2, no data is dropped: full stays high and writes are rejected until count < 2.
- flush: pointers and count go to 0 next cycle; it has priority over rd_en/wr_en that cycle, with those strobes ignored and flags unaffected.
- Reset mid-operation discards all contents; the first write after reset lands at entry 0.

Optional Feature:
- Macro: TUBE_FIFO_ERRFLAGS_EN.
- With it defined:
  - overflow sets on a rejected write (wr_en and not accepted).
  - underflow sets on rd_en with count==0.
  - Both are sticky until rst or flush.
  - flush in the same cycle as an error wins, leaving the flag clear.
- Without it: overflow and underflow are tied to 0 and no flag registers are built.

Decomposition:
- Shared package tube_pkg holds:
  - TUBE_EMPTY_VAL = 8'hAA.
  - Tube register data width constant (8).
  - Default depth constants per Tube register: R1 = 24, rounded to 32; R3 = 2/16.
  - Function clog2 for width sizing.
- Sub-module tube_fifo_ram:
  - WIDTH x DEPTH array, synchronous write, asynchronous read.
  - Kept separate so the vendor distributed-RAM inference is isolated.

Test Plan:
- Reset, then write 0x11,0x22,0x33 -> count=3, data_available=1, rd_data=0x11; three reads return 0x11,0x22,0x33, then rd_data=0xAA and data_available=0.
- DEPTH=16: write 16 bytes 0x00..0x0F -> full=1, almost_full=1 from count=14; a 17th write (0xFF) is dropped and overflow=1 (macro on); reads return 0x00..0x0F.
- Full with simultaneous rd_en and wr_en of 0x55 -> count stays 16; 0x55 is read last after 0x01..0x0F.
- Empty with simultaneous rd_en and wr_en of 0x77 -> count=1 and rd_data=0x77 next cycle; underflow=1 (macro on), 0 (macro off).
- limit_two=1: write 0xA0,0xA1,0xA2 -> third write rejected, full=1, count=2. Load 5 entries with limit_two=0, then set limit_two=1 -> full=1 and no data lost; writes accepted again only after count reaches 1.
- Assert rst mid-burst with count=7 -> outputs return to reset values asynchronously. Separately, flush with wr_en the same cycle -> count=0 next cycle and that write is lost.
